// File: rtl/roll_pkg.sv
// Shared types and constants for the two-player roll scheduler and its MINSTD generator.
package roll_pkg;

    typedef enum logic [1:0] {S_IDLE, S_STEP, S_WAIT, S_DONE} state_t;

    localparam int            SEED_W       = 31;
    localparam int            STAGE_W      = 2;
    localparam int            STEP_W       = 4;
    localparam logic [14:0]   LCG_A        = 15'd16807;
    localparam logic [30:0]   LCG_M        = 31'h7FFF_FFFF;
    localparam int            N_STAGES     = 4;
    localparam int            STAGE0_STEPS = 8;

    // Number of LCG steps taken in a given slow-down stage: 8, 4, 2, 1.
    function automatic logic [STEP_W-1:0] stage_steps(input logic [STAGE_W-1:0] stage);
        stage_steps = STEP_W'(STAGE0_STEPS >> stage);
    endfunction

endpackage

// File: rtl/lcg_minstd.sv
// Combinational MINSTD step: next = 16807 * seed mod (2^31 - 1), using the
// Mersenne fold so no divider is needed.
module lcg_minstd
    import roll_pkg::*;
(
    input  logic [SEED_W-1:0] seed,
    output logic [SEED_W-1:0] next_seed
);

    logic [45:0] prod;
    logic [31:0] fold;

    // Multiply, fold the bits above 2^31 back in, then one conditional subtract.
    always_comb begin
        prod = 46'(seed) * 46'(LCG_A);
        fold = {17'd0, prod[45:31]} + {1'b0, prod[30:0]};
        if (fold >= {1'b0, LCG_M}) begin
            next_seed = fold[30:0] - LCG_M;
        end else begin
            next_seed = fold[30:0];
        end
    end

endmodule

// File: rtl/roll_scheduler.sv
// Two-player roll controller: round-robin arbitration over one shared MINSTD
// stream, 15-step geometric slow-down per roll, per-player latched results.
module roll_scheduler
    import roll_pkg::*;
#(
    parameter int BASE_SHIFT = 23
)
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    output logic       o_busy,
    output logic       o_owner,
    output logic [3:0] o_random_out,
    output logic [3:0] o_result0,
    output logic [3:0] o_result1,
    output logic [1:0] o_done
);

    localparam int CNT_W = BASE_SHIFT + 3;

    state_t              state;
    logic [SEED_W-1:0]   seed;
    logic [SEED_W-1:0]   seed_next;
    logic [1:0]          pending;
    logic [1:0]          req_accept;
    logic                last_owner;
    logic                grant_p;
    logic [STAGE_W-1:0]  stage;
    logic [STEP_W-1:0]   step;
    logic                step_last;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_last;

    lcg_minstd u_lcg (
        .seed      (seed),
        .next_seed (seed_next)
    );

    assign o_busy       = (state != S_IDLE);
    assign o_random_out = seed[3:0];

    // Wait length doubles per stage: 2^(BASE_SHIFT+stage) cycles, counted 0..N-1.
    assign cnt_last  = {CNT_W{1'b1}} >> (2'd3 - stage);
    assign step_last = ((step + STEP_W'(1)) == stage_steps(stage));

    // The owner of a running roll cannot re-request; such pulses are dropped.
    always_comb begin
        req_accept = i_req;
        if (state != S_IDLE) begin
            req_accept[o_owner] = 1'b0;
        end
    end

    // Round-robin pick: a lone requester wins, a tie goes to the other player.
    always_comb begin
        if (pending == 2'b11) begin
            grant_p = ~last_owner;
        end else begin
            grant_p = pending[1];
        end
    end

    // Roll sequencer: grant, step the LCG, wait, repeat through four stages, latch.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            seed       <= 31'd1;
            pending    <= 2'b00;
            last_owner <= 1'b1;
            o_owner    <= 1'b1;
            o_result0  <= 4'd0;
            o_result1  <= 4'd0;
            o_done     <= 2'b00;
            stage      <= '0;
            step       <= '0;
            cnt        <= '0;
        end else begin
            o_done  <= 2'b00;
            pending <= pending | req_accept;
            case (state)
                S_IDLE: begin
                    if (pending != 2'b00) begin
                        o_owner    <= grant_p;
                        last_owner <= grant_p;
                        pending    <= (pending & ~(2'b01 << grant_p)) | req_accept;
                        stage      <= '0;
                        step       <= '0;
                        state      <= S_STEP;
                    end
                end
                S_STEP: begin
                    seed <= seed_next;
                    cnt  <= '0;
                    if (step_last && (stage == STAGE_W'(N_STAGES - 1))) begin
                        state <= S_DONE;
                    end else if (step_last) begin
                        stage <= stage + 2'd1;
                        step  <= '0;
                        state <= S_WAIT;
                    end else begin
                        step  <= step + STEP_W'(1);
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == cnt_last) begin
                        state <= S_STEP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (o_owner) begin
                        o_result1 <= seed[3:0];
                    end else begin
                        o_result0 <= seed[3:0];
                    end
                    o_done <= 2'b01 << o_owner;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/roll_scheduler.md
# roll_scheduler

Two-player roll controller that shares one MINSTD LCG (X(n+1) = 16807·X(n) mod 2^31−1) between two key requesters. It arbitrates round-robin between them and sequences each granted roll through a geometric slow-down schedule of 15 LCG steps. It latches each player's final nibble and drives the live nibble to the 7-segment path. It sits between the debounced key pulses and the display decoders on the DE2-115 board.

## Interface
- BASE_SHIFT, 23: stage-0 wait is 2^BASE_SHIFT cycles (≈0.17 s at 50 MHz); benches use 2.
- i_clk  in  1  system clock, 50 MHz.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req  in  2  one-cycle request pulses, bit p = player p.
- o_busy  out  1  high while a roll is in progress (any state but IDLE).
- o_owner  out  1  player owning the current/last roll.
- o_random_out  out  4  seed[3:0], live value.
- o_result0, o_result1  out  4 each  latched final nibble per player.
- o_done  out  2  one-cycle pulse on bit owner when its result is latched.

## Operation
- Reset values: seed=1, state IDLE, pending=0, last_owner=1, o_owner=1, results=0, o_done=0, o_busy=0, o_random_out=1.
- pending[p] is set on any cycle with i_req[p]=1, except when p==owner and busy. Such requests are dropped, not queued. pending[p] is cleared on grant.
- IDLE: if pending≠0, grant. If one bit is set, grant that player. If both are set, grant !last_owner. Set owner, clear its pending bit, last_owner←owner, stage←0, step←0, go to STEP.
- STEP (1 cycle): seed←lcg(seed); step++.
  - If step reaches steps(stage)=8>>stage and stage==3, go to DONE.
  - If step reaches steps(stage) and stage<3, set stage++, step←0.
  - Otherwise go to WAIT with cnt←0.
- WAIT: cnt++ until cnt==2^(BASE_SHIFT+stage)−1, then go to STEP. The period uses the stage of the next step.
- DONE (1 cycle): result[owner]←seed[3:0], o_done[owner]=1, go to IDLE.
- Step counts per stage are 8, 4, 2, 1, for 15 LCG steps per roll. The seed is shared and never reseeded except by reset, so players draw successive values of one stream.
- Arithmetic: 31-bit seed. Form the 46-bit product, then fold: r = p[45:31] + p[30:0]. If r ≥ 2^31−1, subtract 2^31−1. The seed never becomes 0 or 2^31−1.
- Counter cnt is BASE_SHIFT+3 bits wide; it cannot wrap within a stage.

## Timing
- i_req at edge k sets pending at k. The grant is taken at edge k+1, and the first seed update happens at edge k+2.
- A roll from grant to DONE exit lasts 1 + 15 + 1 + Σwaits cycles.
  - Σwaits = 7·2^B + 4·2^(B+1) + 2·2^(B+2) + 2^(B+3), where B = BASE_SHIFT.
  - For B=2 this is 124, so a roll takes 141 cycles.
- A request arriving during DONE is granted in the IDLE cycle that follows, with no extra idle cycle.
- Reset mid-roll aborts immediately. No done pulse is produced, pending is lost, and results return to 0.

## Structure
- roll_pkg:
  - state enum {S_IDLE, S_STEP, S_WAIT, S_DONE}.
  - LCG_A=16807, LCG_M=2^31−1, N_STAGES=4, STAGE0_STEPS=8.
- Sub-module lcg_minstd: purely combinational, seed in, next seed out, containing the fold/subtract above. It is reused by later labs.

## Test plan
- Reset, then i_req=2'b01 pulse (B=2):
  - o_random_out sequence starts 7 (16807 mod 16).
  - 15th value is 114807987 → o_result0=3.
  - o_done=2'b01 for exactly 1 cycle, 141 cycles after grant.
  - o_result1 remains 0.
- Both i_req bits pulse in the same cycle after reset: player 0 is granted first. Player 1 is granted in the IDLE cycle after player 0's DONE and continues the stream (seed = 16th MINSTD value), not reseeding.
- i_req[0] pulsed again mid-roll by owner 0: ignored. Only one o_done[0] pulse occurs and o_busy falls once.
- i_req[1] pulsed during player 0's WAIT: pending held. Player 1's roll starts with no idle gap. o_owner switches 0→1 at grant.
- Measure WAIT lengths between o_random_out changes: 7×4, 4×8, 2×16, 1×32 cycles (plus 1 STEP cycle each).
- Assert i_rst_n low during stage-2 WAIT: o_busy=0 and results=0 asynchronously, seed=1. A subsequent roll reproduces the first-roll values.
